// File: rtl/uart_rgb_loader.sv
// Packs a raster-order R,G,B UART byte stream into 16-bit SRAM words laid out as
// red interleaved pairs plus even/odd green and blue planes for the VGA fetch stage.
module uart_rgb_loader #(
    parameter int          NUM_PIXEL_GROUPS  = 19200,
    parameter logic [17:0] GREEN_EVEN_OFFSET = 18'd38400,
    parameter logic [17:0] GREEN_ODD_OFFSET  = 18'd57600,
    parameter logic [17:0] BLUE_EVEN_OFFSET  = 18'd76800,
    parameter logic [17:0] BLUE_ODD_OFFSET   = 18'd96000
) (
    input  logic        Clock_50,
    input  logic        Reset,
    input  logic        Start,
    input  logic [7:0]  UART_rx_data,
    input  logic        UART_rx_valid,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        Busy,
    output logic        Done,
    output logic [14:0] group_count
);

    localparam logic [14:0] LAST_GROUP = 15'(NUM_PIXEL_GROUPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOADING, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_byte_idx;
    logic [10:0][7:0]   r_cap;
    logic [5:0][15:0]   r_hold;
    logic               r_wr_active;
    logic [2:0]         r_w;
    logic [14:0]        r_group_count;
    logic [17:0]        r_addr;
    logic [15:0]        r_data;
    logic               r_we_n;

    logic [17:0]        w_k;
    logic [17:0]        w_wr_addr;
    logic [15:0]        w_wr_data;
    logic               w_last_write;
    logic               w_final_write;
    logic               w_byte_in;

    assign w_k           = {3'b000, r_group_count};
    assign w_last_write  = r_wr_active && (r_w == 3'd5);
    assign w_final_write = w_last_write && (r_group_count == LAST_GROUP);
    assign w_byte_in     = (r_state == S_LOADING) && UART_rx_valid;

    always_ff @(posedge Clock_50) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (Start)
            w_state_nxt = S_LOADING;
        else if (r_state == S_LOADING && w_final_write)
            w_state_nxt = S_DONE;
    end

    // Write order within a burst: green-even, blue-even, green-odd, blue-odd, red pair 0, red pair 1
    always_comb begin
        w_wr_addr = '0;
        w_wr_data = '0;
        case (r_w)
            3'd0: begin w_wr_addr = GREEN_EVEN_OFFSET + w_k; w_wr_data = r_hold[0]; end
            3'd1: begin w_wr_addr = BLUE_EVEN_OFFSET + w_k;  w_wr_data = r_hold[1]; end
            3'd2: begin w_wr_addr = GREEN_ODD_OFFSET + w_k;  w_wr_data = r_hold[2]; end
            3'd3: begin w_wr_addr = BLUE_ODD_OFFSET + w_k;   w_wr_data = r_hold[3]; end
            3'd4: begin w_wr_addr = {w_k[16:0], 1'b0};       w_wr_data = r_hold[4]; end
            default: begin w_wr_addr = {w_k[16:0], 1'b1};    w_wr_data = r_hold[5]; end
        endcase
    end

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            r_byte_idx    <= '0;
            r_cap         <= '0;
            r_hold        <= '0;
            r_wr_active   <= 1'b0;
            r_w           <= '0;
            r_group_count <= '0;
            r_addr        <= '0;
            r_data        <= '0;
            r_we_n        <= 1'b1;
        end else if (Start) begin
            r_byte_idx    <= '0;
            r_wr_active   <= 1'b0;
            r_w           <= '0;
            r_group_count <= '0;
            r_we_n        <= 1'b1;
        end else begin
            if (r_wr_active) begin
                r_addr <= w_wr_addr;
                r_data <= w_wr_data;
                r_we_n <= 1'b0;
                if (w_last_write) begin
                    r_wr_active   <= 1'b0;
                    r_group_count <= r_group_count + 15'd1;
                end else begin
                    r_w <= r_w + 3'd1;
                end
            end else begin
                r_we_n <= 1'b1;
            end

            // Slots: R0 G0 B0 R1 G1 B1 R2 G2 B2 R3 G3; B3 is the byte arriving now
            if (w_byte_in) begin
                if (r_byte_idx == 4'd11) begin
                    r_hold[0]   <= {r_cap[1], r_cap[7]};
                    r_hold[1]   <= {r_cap[2], r_cap[8]};
                    r_hold[2]   <= {r_cap[4], r_cap[10]};
                    r_hold[3]   <= {r_cap[5], UART_rx_data};
                    r_hold[4]   <= {r_cap[0], r_cap[3]};
                    r_hold[5]   <= {r_cap[6], r_cap[9]};
                    r_wr_active <= 1'b1;
                    r_w         <= '0;
                    r_byte_idx  <= '0;
                end else begin
                    r_cap[r_byte_idx] <= UART_rx_data;
                    r_byte_idx        <= r_byte_idx + 4'd1;
                end
            end
        end
    end

    assign SRAM_address    = r_addr;
    assign SRAM_write_data = r_data;
    assign SRAM_we_n       = r_we_n;
    assign Busy            = (r_state == S_LOADING);
    assign Done            = (r_state == S_DONE);
    assign group_count     = r_group_count;

endmodule

// File: tb/tb_uart_rgb_loader.sv
// Randomized scoreboard bench for uart_rgb_loader: a pixel-level reference model
// predicts SRAM writes, a monitor compares them and fills a bench SRAM image.
module tb_uart_rgb_loader;

    localparam int          G  = 8;
    localparam logic [17:0] GE = 18'd38400;
    localparam logic [17:0] GO = 18'd57600;
    localparam logic [17:0] BE = 18'd76800;
    localparam logic [17:0] BO = 18'd96000;

    logic        Clock_50 = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [7:0]  UART_rx_data = 8'h00;
    logic        UART_rx_valid = 1'b0;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        Busy;
    logic        Done;
    logic [14:0] group_count;

    uart_rgb_loader #(.NUM_PIXEL_GROUPS(G)) dut (
        .Clock_50(Clock_50), .Reset(Reset), .Start(Start),
        .UART_rx_data(UART_rx_data), .UART_rx_valid(UART_rx_valid),
        .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n(SRAM_we_n), .Busy(Busy), .Done(Done), .group_count(group_count)
    );

    always #5 Clock_50 = ~Clock_50;

    typedef struct { logic [17:0] a; logic [15:0] d; } wr_t;

    wr_t         q[$];
    logic [15:0] mem[int];
    logic [7:0]  grp[$];
    logic [7:0]  frame[$];
    int          mdl_k = 0;
    bit          mdl_loading = 0;
    int          total = 0;
    int          bad = 0;
    bit          mon_en = 0;
    bit          skip_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: pixel j of group k has R=b[3j], G=b[3j+1], B=b[3j+2]
    function automatic void push_group(input int k, input logic [7:0] b[12]);
        logic [17:0] kk;
        kk = 18'(k);
        q.push_back('{GE + kk,       {b[1], b[7]}});
        q.push_back('{BE + kk,       {b[2], b[8]}});
        q.push_back('{GO + kk,       {b[4], b[10]}});
        q.push_back('{BO + kk,       {b[5], b[11]}});
        q.push_back('{18'(2*k),      {b[0], b[3]}});
        q.push_back('{18'(2*k + 1),  {b[6], b[9]}});
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic [7:0] arr[12];
        if (!mdl_loading) return;
        frame.push_back(b);
        grp.push_back(b);
        if (grp.size() == 12) begin
            for (int i = 0; i < 12; i++) arr[i] = grp[i];
            push_group(mdl_k, arr);
            grp.delete();
            mdl_k++;
            if (mdl_k == G) mdl_loading = 0;
        end
    endfunction

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) begin @(posedge Clock_50); #1; end
        UART_rx_data  = b;
        UART_rx_valid = 1'b1;
        model_byte(b);
        @(posedge Clock_50); #1;
        UART_rx_valid = 1'b0;
    endtask

    task automatic do_start(input bit with_byte);
        Start = 1'b1;
        if (with_byte) begin
            UART_rx_data  = 8'hEE;
            UART_rx_valid = 1'b1;
        end
        @(posedge Clock_50); #1;
        Start = 1'b0;
        UART_rx_valid = 1'b0;
        q.delete();
        grp.delete();
        frame.delete();
        mdl_k = 0;
        mdl_loading = 1;
        chk("start_busy", 32'(Busy), 32'd1);
        chk("start_done", 32'(Done), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || !SRAM_we_n) && n < 300) begin
            @(posedge Clock_50); #1;
            n++;
        end
        chk("drain_in_time", 32'(n < 300), 32'd1);
        repeat (3) begin @(posedge Clock_50); #1; end
    endtask

    // Monitor: every low SRAM_we_n cycle is one write to account for
    initial begin
        int  run = 0;
        wr_t e;
        forever begin
            @(negedge Clock_50);
            if (mon_en) begin
                if (!SRAM_we_n) begin
                    run++;
                    mem[int'(SRAM_address)] = SRAM_write_data;
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write: addr %0d data %h, none expected",
                                 SRAM_address, SRAM_write_data);
                    end else begin
                        e = q.pop_front();
                        chk("wr_addr", 32'(SRAM_address), 32'(e.a));
                        chk("wr_data", 32'(SRAM_write_data), 32'(e.d));
                    end
                end else if (run > 0) begin
                    if (!skip_run) chk("burst_len", 32'(run), 32'd6);
                    run = 0;
                    skip_run = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] dir[12];
        int         k, j;
        logic [17:0] a;
        logic [15:0] w;

        repeat (3) @(posedge Clock_50);
        #1 Reset = 1'b0;
        mon_en = 1;
        chk("rst_addr", 32'(SRAM_address), 32'd0);
        chk("rst_data", 32'(SRAM_write_data), 32'd0);
        chk("rst_we_n", 32'(SRAM_we_n), 32'd1);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_gc", 32'(group_count), 32'd0);

        // Bytes in idle must be ignored
        for (int i = 0; i < 5; i++) send(8'($urandom), 0);
        repeat (4) begin @(posedge Clock_50); #1; end
        chk("idle_busy", 32'(Busy), 32'd0);

        // Directed single group, with a byte coinciding with Start
        do_start(1);
        dir = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        for (int i = 0; i < 11; i++) send(dir[i], $urandom_range(0, 1));
        send(dir[11], 0);
        chk("lat_we_n_t", 32'(SRAM_we_n), 32'd1);
        @(posedge Clock_50); #1;
        chk("lat_we_n_t1", 32'(SRAM_we_n), 32'd0);
        chk("lat_addr_t1", 32'(SRAM_address), 32'd38400);
        chk("lat_data_t1", 32'(SRAM_write_data), 32'h2288);
        drain();
        chk("one_gc", 32'(group_count), 32'd1);

        // Back-to-back strobes, 24 bytes
        do_start(0);
        for (int i = 0; i < 24; i++) send(8'($urandom), 0);
        drain();
        chk("b2b_gc", 32'(group_count), 32'd2);
        chk("b2b_busy", 32'(Busy), 32'd1);

        // Restart after a partial group
        do_start(0);
        for (int i = 0; i < 7; i++) send(8'($urandom), 0);
        do_start(0);
        for (int i = 0; i < 12; i++) send(8'($urandom), $urandom_range(0, 2));
        drain();
        chk("restart_gc", 32'(group_count), 32'd1);
        chk("restart_done", 32'(Done), 32'd0);

        // Reset in the middle of a burst: sampled on edge t+3
        do_start(0);
        skip_run = 1;
        for (int i = 0; i < 12; i++) send(8'($urandom), 0);
        @(posedge Clock_50); #1;
        @(posedge Clock_50); #1;
        Reset = 1'b1;
        @(posedge Clock_50); #1;
        Reset = 1'b0;
        q.delete();
        mdl_loading = 0;
        chk("mid_rst_we_n", 32'(SRAM_we_n), 32'd1);
        chk("mid_rst_addr", 32'(SRAM_address), 32'd0);
        chk("mid_rst_data", 32'(SRAM_write_data), 32'd0);
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        chk("mid_rst_gc", 32'(group_count), 32'd0);
        repeat (10) begin @(posedge Clock_50); #1; end
        do_start(0);
        for (int i = 0; i < 12; i++) send(8'($urandom), 0);
        drain();
        chk("post_rst_gc", 32'(group_count), 32'd1);

        // Full frame with random gaps, checked through the bench SRAM image
        mem.delete();
        do_start(0);
        for (int i = 0; i < G * 12; i++) send(8'($urandom), $urandom_range(0, 2));
        drain();
        chk("frame_done", 32'(Done), 32'd1);
        chk("frame_busy", 32'(Busy), 32'd0);
        chk("frame_gc", 32'(group_count), 32'(G));
        for (int p = 0; p < G * 4; p++) begin
            k = p / 4;
            j = p % 4;
            a = 18'(2 * k + j / 2);
            w = mem.exists(int'(a)) ? mem[int'(a)] : 16'hxxxx;
            chk("img_red", 32'((j % 2 == 0) ? w[15:8] : w[7:0]), 32'(frame[3*p]));
            a = ((j % 2 == 0) ? GE : GO) + 18'(k);
            w = mem.exists(int'(a)) ? mem[int'(a)] : 16'hxxxx;
            chk("img_green", 32'((j < 2) ? w[15:8] : w[7:0]), 32'(frame[3*p+1]));
            a = ((j % 2 == 0) ? BE : BO) + 18'(k);
            w = mem.exists(int'(a)) ? mem[int'(a)] : 16'hxxxx;
            chk("img_blue", 32'((j < 2) ? w[15:8] : w[7:0]), 32'(frame[3*p+2]));
        end
        chk("last_blue_odd", 32'(mem.exists(int'(BO + 18'(G - 1)))), 32'd1);

        // Bytes after Done produce no writes
        for (int i = 0; i < 24; i++) send(8'($urandom), 0);
        repeat (20) begin @(posedge Clock_50); #1; end
        chk("after_done_gc", 32'(group_count), 32'(G));
        chk("after_done_done", 32'(Done), 32'd1);
        chk("after_done_we_n", 32'(SRAM_we_n), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rgb_loader.md
# uart_rgb_loader

Upstream image-load stage for the SRAM/VGA display path. Accepts a raster-order RGB byte stream from the UART receiver (R,G,B per pixel, 320x240 pixels) and packs it into 16-bit SRAM words in the split layout the VGA fetch stage reads back:

- Red interleaved pairs at addresses 0..38399.
- Green and blue separated into even-pixel and odd-pixel planes.

While Busy, it owns the SRAM controller's write port.

## Interface
- NUM_PIXEL_GROUPS, 19200 — groups of 4 pixels per frame (320x240/4)
- GREEN_EVEN_OFFSET, 18'd38400 — base of green plane, pixels 4k/4k+2
- GREEN_ODD_OFFSET, 18'd57600 — base of green plane, pixels 4k+1/4k+3
- BLUE_EVEN_OFFSET, 18'd76800 — base of blue plane, pixels 4k/4k+2
- BLUE_ODD_OFFSET, 18'd96000 — base of blue plane, pixels 4k+1/4k+3

Ports (one clock; reset is synchronous and active-high):
- Clock_50  in  1  50 MHz clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  one-cycle pulse; begins or restarts a frame load
- UART_rx_data  in  8  received byte
- UART_rx_valid  in  1  one-cycle strobe; UART_rx_data valid this cycle; may be asserted back-to-back
- SRAM_address  out  18  write address to SRAM controller (registered)
- SRAM_write_data  out  16  write data (registered)
- SRAM_we_n  out  1  active-low write enable (registered)
- Busy  out  1  high from the cycle after Start until load completes
- Done  out  1  high after the final write; held until next Start or Reset
- group_count  out  15  completed 4-pixel groups written this frame

## Operation
- Top states:
  - S_IDLE: bytes ignored.
  - S_LOADING
  - S_DONE: bytes ignored.
- Transitions:
  - Start in any state → S_LOADING. Clears byte_idx, group_count, the write sequencer and Done. SRAM_we_n returns high the next cycle, abandoning any burst in progress.
  - S_LOADING → S_DONE when the 6th write of group NUM_PIXEL_GROUPS-1 is issued.
  - In S_DONE, Done=1 and Busy=0.
- Capture (in S_LOADING):
  - byte_idx runs 0..11 and wraps.
  - Each valid byte is stored in capture slot byte_idx. Slot order: R0 G0 B0 R1 G1 B1 R2 G2 B2 R3 G3 B3.
  - On the byte with byte_idx=11, all 12 bytes (including the current one) are copied into a 6-word write-holding register, and the write sequencer is triggered for group k=group_count.
- Write sequencer, 6 consecutive writes, index w=0..5:
  - w0: address GREEN_EVEN_OFFSET+k, data {G0,G2}
  - w1: address BLUE_EVEN_OFFSET+k, data {B0,B2}
  - w2: address GREEN_ODD_OFFSET+k, data {G1,G3}
  - w3: address BLUE_ODD_OFFSET+k, data {B1,B3}
  - w4: address 2k, data {R0,R1}
  - w5: address 2k+1, data {R2,R3}
  - group_count increments when w5 is issued.
- Capture of the next group continues during the burst. The next trigger needs at least 12 more strobes, which takes at least 12 cycles, while the burst takes 6 cycles. Overlap is therefore impossible and no overflow flag is needed.
- Address arithmetic is 18-bit unsigned; 2k+1 max = 38399 and BLUE_ODD_OFFSET+k max = 115199, so no wrap.
- Reset values: SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1, Busy=0, Done=0, group_count=0, byte_idx=0, state S_IDLE.

## Timing
- Let the 12th byte of a group be sampled on edge t:
  - Edges t+1..t+6 present w0..w5 on the registered outputs, with SRAM_we_n=0 for exactly 6 cycles.
  - SRAM_we_n=1 from edge t+7 unless a new burst starts.
- Latency from the 12th byte to the first write is 1 cycle; the SRAM controller adds its own fixed latency downstream.
- Done and group_count update on the edge that presents the last group's w5. Busy falls on the same edge.
- Start at edge s: Busy=1 and Done=0 from s+1. A byte strobed in the same cycle as Start is ignored.
- Reset mid-burst: outputs take their reset values at the next edge; no further writes.

## Test plan
- Single group after Start: bytes 11,22,33,44,55,66,77,88,99,AA,BB,CC (hex) → writes in order 38400←2288, 76800←3399, 57600←55BB, 96000←66CC, 0←1144, 1←77AA. SRAM_we_n low exactly 6 cycles.
- Back-to-back strobes (valid every cycle, 24 bytes) → two non-overlapping 6-write bursts for k=0 and k=1. Second group at 38401, 76801, 57601, 96001, 2, 3. group_count=2.
- Full frame of 230400 bytes with a pattern checked in a bench SRAM model → last group writes to 57599, 95999, 76799, 115199, 38398, 38399. Done=1, Busy=0, group_count=19200. Further bytes produce no writes.
- Bytes strobed in S_IDLE (before Start) → no writes, byte_idx stays 0. The first group after Start uses only post-Start bytes.
- Reset asserted at edge t+3 of a burst → SRAM_we_n=1, address/data=0, Busy=0 from the next edge. A subsequent Start plus 12 bytes writes to k=0 addresses.
- Start re-pulsed after 7 bytes of a group → partial bytes discarded. The next 12 bytes form group k=0 with Done=0.
